// File: rtl/phy_tx_pkg.sv
// Shared definitions for the PHY transmit lane scheduler.
//   state_t    : link controller state encoding
//   COMMA_DEF  : K28.5 comma used for training and idle fill
//   NUM_LANES  : number of lane requesters sharing the byte stream
//   sat_inc4   : 4-bit saturating increment for the retrain counter
package phy_tx_pkg;

    typedef enum logic [1:0] {
        TRAIN     = 2'd0,
        WAIT_LOCK = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    localparam logic [7:0] COMMA_DEF = 8'hBC;
    localparam int         NUM_LANES = 4;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter.
//   clk, reset : byte clock, asynchronous active-low reset
//   req        : per-lane requests (already gated by the caller)
//   grant      : one-hot combinational grant, zero when no request
//   grant_idx  : index of the granted lane (meaningful when grant != 0)
// A grant is always accepted (grant only goes to a requesting lane), so the
// last-served pointer advances on any grant. Reset value 3 gives lane 0
// first priority.
module rr_arbiter4
    import phy_tx_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] req,
    output logic [NUM_LANES-1:0] grant,
    output logic [1:0]           grant_idx
);

    logic [1:0] last_q;
    logic [1:0] last_d;
    logic [1:0] cand;

    // Scan from lowest priority (last) up to highest (last+1); the final
    // matching candidate overwrites earlier ones, so last+1 wins.
    always_comb begin
        grant     = '0;
        grant_idx = last_q;
        cand      = last_q;
        for (int i = NUM_LANES; i >= 1; i--) begin
            cand = last_q + 2'(i);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        last_d = (|grant) ? grant_idx : last_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 2'd3;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/phy_tx_lane_sched.sv
// PHY transmit link controller and lane byte scheduler.
//   clk            : byte clock
//   reset          : asynchronous active-low reset
//   in0..in3       : lane data bytes
//   valid0..valid3 : lane byte available
//   ready0..ready3 : lane byte accepted this cycle (combinational)
//   rx_lock        : receiver lock, synchronous to clk
//   out_data       : registered byte to the serializer
//   out_valid      : out_data carries a lane byte
//   out_k          : out_data is a comma
//   link_up        : registered, high while ACTIVE
//   retrain_cnt    : saturating count of retrains
// Trains with commas, waits for rx_lock, then round-robins four lanes onto
// the byte stream, filling idle cycles with commas. In ACTIVE a single low
// rx_lock cycle is tolerated; a second consecutive low cycle retrains.
module phy_tx_lane_sched
    import phy_tx_pkg::*;
#(
    parameter int         TRAIN_LEN    = 16,
    parameter int         LOCK_TIMEOUT = 255,
    parameter logic [7:0] COMMA        = COMMA_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       valid2,
    input  logic       valid3,
    output logic       ready0,
    output logic       ready1,
    output logic       ready2,
    output logic       ready3,
    input  logic       rx_lock,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_k,
    output logic       link_up,
    output logic [3:0] retrain_cnt
);

    localparam int CNT_MAX = (TRAIN_LEN > LOCK_TIMEOUT) ? TRAIN_LEN : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               low_q, low_d;
    logic [3:0]         retrain_q, retrain_d;
    logic               link_up_q, link_up_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_k_q, out_k_d;

    logic [7:0]           lane_data [NUM_LANES];
    logic [NUM_LANES-1:0] lane_valid;
    logic [NUM_LANES-1:0] req;
    logic [NUM_LANES-1:0] grant;
    logic [1:0]           grant_idx;
    logic                 lock_drop;
    logic                 arb_en;
    logic                 xfer;

    assign lane_data[0] = in0;
    assign lane_data[1] = in1;
    assign lane_data[2] = in2;
    assign lane_data[3] = in3;
    assign lane_valid   = {valid3, valid2, valid1, valid0};

    // Second consecutive low rx_lock sample in ACTIVE: leave this cycle and
    // grant nothing in it.
    assign lock_drop = (state_q == ACTIVE) && !rx_lock && low_q;
    assign arb_en    = (state_q == ACTIVE) && !lock_drop;
    assign req       = lane_valid & {NUM_LANES{arb_en}};

    rr_arbiter4 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign ready0 = grant[0];
    assign ready1 = grant[1];
    assign ready2 = grant[2];
    assign ready3 = grant[3];
    assign xfer   = |grant;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retrain_d = retrain_q;
        case (state_q)
            TRAIN: begin
                if (cnt_q == CNT_W'(TRAIN_LEN - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                // Lock takes precedence over a coincident timeout.
                if (rx_lock) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d   = TRAIN;
                    cnt_d     = '0;
                    retrain_d = sat_inc4(retrain_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACTIVE: begin
                cnt_d = '0;
                if (lock_drop) begin
                    state_d   = TRAIN;
                    retrain_d = sat_inc4(retrain_q);
                end
            end
            default: begin
                state_d = TRAIN;
                cnt_d   = '0;
            end
        endcase

        low_d     = (state_q == ACTIVE) && !rx_lock;
        link_up_d = (state_d == ACTIVE);

        if (xfer) begin
            out_data_d  = lane_data[grant_idx];
            out_valid_d = 1'b1;
            out_k_d     = 1'b0;
        end else begin
            out_data_d  = COMMA;
            out_valid_d = 1'b0;
            out_k_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= TRAIN;
            cnt_q       <= '0;
            low_q       <= 1'b0;
            retrain_q   <= 4'd0;
            link_up_q   <= 1'b0;
            out_data_q  <= COMMA;
            out_valid_q <= 1'b0;
            out_k_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            low_q       <= low_d;
            retrain_q   <= retrain_d;
            link_up_q   <= link_up_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_k_q     <= out_k_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_k       = out_k_q;
    assign link_up     = link_up_q;
    assign retrain_cnt = retrain_q;

endmodule

// File: tb/tb_phy_tx_lane_sched.sv
module tb_phy_tx_lane_sched;

    localparam int TL = 16;
    localparam int LT = 255;

    logic       clk;
    logic       reset;
    logic [7:0] in_v [4];
    logic [3:0] valid_v;
    logic       rx_lock;
    logic       ready0, ready1, ready2, ready3;
    logic [7:0] out_data;
    logic       out_valid, out_k, link_up;
    logic [3:0] retrain_cnt;

    int n_vec = 0;
    int n_err = 0;

    phy_tx_lane_sched #(.TRAIN_LEN(TL), .LOCK_TIMEOUT(LT), .COMMA(8'hBC)) dut (
        .clk         (clk),
        .reset       (reset),
        .in0         (in_v[0]),
        .in1         (in_v[1]),
        .in2         (in_v[2]),
        .in3         (in_v[3]),
        .valid0      (valid_v[0]),
        .valid1      (valid_v[1]),
        .valid2      (valid_v[2]),
        .valid3      (valid_v[3]),
        .ready0      (ready0),
        .ready1      (ready1),
        .ready2      (ready2),
        .ready3      (ready3),
        .rx_lock     (rx_lock),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_k       (out_k),
        .link_up     (link_up),
        .retrain_cnt (retrain_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h at %0t", name, act, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 training, 1 waiting for lock, 2 active
    int         m_phase, m_count, m_last, m_retr, m_gl;
    bit         m_prev_low, m_link, m_ov, m_ok;
    logic [7:0] m_out;
    logic [3:0] m_ready;

    task automatic model_reset();
        m_phase = 0; m_count = 0; m_last = 3; m_retr = 0;
        m_prev_low = 0; m_link = 0; m_ov = 0; m_ok = 1; m_out = 8'hBC;
    endtask

    task automatic model_eval();
        m_gl = -1;
        m_ready = 4'b0;
        if (m_phase == 2 && !(m_prev_low && !rx_lock)) begin
            for (int k = 1; k <= 4; k++) begin
                int l;
                l = (m_last + k) % 4;
                if (m_gl < 0 && valid_v[l]) m_gl = l;
            end
        end
        if (m_gl >= 0) m_ready[m_gl] = 1'b1;
    endtask

    task automatic model_step();
        int nph;
        nph = m_phase;
        if (m_phase == 0) begin
            if (m_count == TL - 1) begin nph = 1; m_count = 0; end
            else m_count++;
        end else if (m_phase == 1) begin
            if (rx_lock) begin nph = 2; m_count = 0; end
            else if (m_count == LT - 1) begin
                nph = 0; m_count = 0;
                if (m_retr < 15) m_retr++;
            end else m_count++;
        end else begin
            if (m_prev_low && !rx_lock) begin
                nph = 0;
                if (m_retr < 15) m_retr++;
            end
        end
        m_prev_low = (m_phase == 2) && !rx_lock;
        if (m_gl >= 0) begin
            m_out = in_v[m_gl]; m_ov = 1; m_ok = 0; m_last = m_gl;
        end else begin
            m_out = 8'hBC; m_ov = 0; m_ok = 1;
        end
        m_phase = nph;
        m_link = (nph == 2);
    endtask

    // Per-cycle comparison on the falling edge, then advance the model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset) model_reset();
            model_eval();
            check("cycle {rdy,data,v,k,link,retr}",
                  32'({ready3, ready2, ready1, ready0, out_data, out_valid, out_k, link_up, retrain_cnt}),
                  32'({m_ready, m_out, m_ov, m_ok, m_link, m_retr[3:0]}));
            if (reset) model_step();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_link(input int limit, output int cycles);
        cycles = 0;
        while (!link_up && cycles < limit) begin
            tick();
            cycles++;
        end
        if (!link_up) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_link: link_up still 0 after %0d cycles", cycles);
        end
    endtask

    initial begin
        int cyc;
        reset   = 1'b0;
        rx_lock = 1'b1;
        valid_v = 4'b0;
        for (int k = 0; k < 4; k++) in_v[k] = 8'h10 + 8'(k);

        repeat (3) @(posedge clk);
        #1;
        check("reset out_data", 32'(out_data), 32'h00BC);
        check("reset k/v/link/retr/rdy",
              32'({out_k, out_valid, link_up, retrain_cnt, ready3, ready2, ready1, ready0}),
              32'({1'b1, 1'b0, 1'b0, 4'd0, 4'd0}));

        // Bring-up: 16 training commas + one WAIT_LOCK cycle.
        reset = 1'b1;
        wait_link(60, cyc);
        check("bringup cycles", 32'(cyc), 32'(TL + 1));
        check("active idle comma", 32'({out_k, out_valid, out_data}), 32'({1'b1, 1'b0, 8'hBC}));

        // All four lanes requesting: strict rotation 0,1,2,3.
        valid_v = 4'hF;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr4 data", 32'({out_valid, out_data}), 32'({1'b1, 8'h10 + 8'(i % 4)}));
        end

        // Only lanes 1 and 3: alternate, lanes 0 and 2 never granted.
        valid_v = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr13 data", 32'(out_data), (i % 2 == 0) ? 32'h11 : 32'h13);
            check("rr13 rdy0/2", 32'({ready0, ready2}), 32'd0);
        end

        // One low rx_lock cycle is filtered.
        rx_lock = 1'b0;
        tick();
        rx_lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("glitch link/valid", 32'({link_up, out_valid}), 32'b11);
        end

        // Two low cycles drop the link.
        rx_lock = 1'b0;
        tick();
        tick();
        check("drop link/v/k", 32'({link_up, out_valid, out_k}), 32'b001);
        check("drop retrain", 32'(retrain_cnt), 32'd1);

        // Hold rx_lock low: one retrain every TL+LT cycles, saturating.
        repeat (TL + LT - 1) tick();
        check("timeout not yet", 32'(retrain_cnt), 32'd1);
        tick();
        check("timeout retrain", 32'(retrain_cnt), 32'd2);
        repeat (15 * (TL + LT)) tick();
        check("retrain saturate", 32'(retrain_cnt), 32'd15);

        // Recover, stream, then reset asynchronously mid-stream.
        rx_lock = 1'b1;
        wait_link(400, cyc);
        valid_v = 4'hF;
        tick();
        tick();
        check("stream before reset", 32'(out_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async reset data/k/v", 32'({out_data, out_k, out_valid}), 32'({8'hBC, 1'b1, 1'b0}));
        check("async reset rdy/link/retr",
              32'({ready3, ready2, ready1, ready0, link_up, retrain_cnt}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        valid_v = 4'h0;
        wait_link(60, cyc);
        check("rebringup cycles", 32'(cyc), 32'(TL + 1));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
